// File: rtl/rsa_crypt.sv
// Modular-exponentiation engine: result = msg^exp mod n, computed with a
// fixed EXP_WIDTH-iteration right-to-left square-and-multiply loop.
module rsa_crypt #(
  parameter int WIDTH     = 7,
  parameter int EXP_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     mod_in,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int CW = $clog2(EXP_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(EXP_WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Divisors are forced non-zero so the dividers never see /0; the zero-modulus
  // case is rejected in IDLE before any loaded value is used.
  logic [WIDTH-1:0]     mod_in_nz;
  logic [WIDTH-1:0]     mod_it_nz;
  logic [WIDTH-1:0]     base_load;
  logic [WIDTH-1:0]     acc_load;
  logic [2*WIDTH-1:0]   prod_ab;
  logic [2*WIDTH-1:0]   prod_bb;
  logic [2*WIDTH-1:0]   mod_wide;
  logic [WIDTH-1:0]     acc_mul;
  logic [WIDTH-1:0]     base_sq;
  logic [WIDTH-1:0]     acc_next;

  always_comb begin
    mod_in_nz = (mod_in == '0) ? WIDTH'(1) : mod_in;
    mod_it_nz = (mod_q == '0) ? WIDTH'(1) : mod_q;
    base_load = msg_in % mod_in_nz;
    acc_load  = WIDTH'(1) % mod_in_nz;
    prod_ab   = (2*WIDTH)'(acc_q) * (2*WIDTH)'(base_q);
    prod_bb   = (2*WIDTH)'(base_q) * (2*WIDTH)'(base_q);
    mod_wide  = (2*WIDTH)'(mod_it_nz);
    acc_mul   = WIDTH'(prod_ab % mod_wide);
    base_sq   = WIDTH'(prod_bb % mod_wide);
    acc_next  = exp_q[0] ? acc_mul : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      result_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    mod_d    = mod_q;
    result_d = result_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mod_in == '0) begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            mod_d   = mod_in;
            exp_d   = exp_in;
            base_d  = base_load;
            acc_d   = acc_load;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        acc_d = acc_next;
        base_d = base_sq;
        exp_d = exp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Every iteration runs regardless of exponent bits: constant latency.
        if (cnt_q == LAST_CNT) begin
          result_d = acc_next;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == ITER);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
